// File: rtl/asrv32_decode_stage_if.sv
// Fetch-to-decode input handshake and decoded-output bus of the RV32 decode stage.
interface asrv32_decode_stage_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic [31:0]         i_inst;
    logic [PC_WIDTH-1:0] i_pc;
    logic                i_valid;
    logic                o_ready;
    logic                i_ready;
    logic                i_flush;
    logic                o_valid;
    logic [PC_WIDTH-1:0] o_pc;
    logic [4:0]          o_rs1_addr;
    logic [4:0]          o_rs2_addr;
    logic [4:0]          o_rd_addr;
    logic [31:0]         o_imm;
    logic [2:0]          o_funct3;
    logic [10:0]         o_opcode;
    logic [13:0]         o_alu_op;
    logic                o_rd_we;
    logic                o_illegal;

    modport slave (
        input  i_inst, i_pc, i_valid, i_ready, i_flush,
        output o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_imm, o_funct3, o_opcode, o_alu_op, o_rd_we, o_illegal
    );

    modport master (
        output i_inst, i_pc, i_valid, i_ready, i_flush,
        input  o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_imm, o_funct3, o_opcode, o_alu_op, o_rd_we, o_illegal
    );
endinterface

// File: rtl/asrv32_decode_stage.sv
// RV32I/E decode stage: combinational decode of the incoming word into a
// single elastic output register with valid/ready handshake and flush.
module asrv32_decode_stage #(
    parameter bit          RV32E    = 1'b0,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    asrv32_decode_stage_if.slave  dec
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned IMM_W = 32;
    localparam int unsigned OPC_W = 11;
    localparam int unsigned ALU_W = 14;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam int unsigned OP_RTYPE  = 0;
    localparam int unsigned OP_ITYPE  = 1;
    localparam int unsigned OP_LOAD   = 2;
    localparam int unsigned OP_STORE  = 3;
    localparam int unsigned OP_BRANCH = 4;
    localparam int unsigned OP_JAL    = 5;
    localparam int unsigned OP_JALR   = 6;
    localparam int unsigned OP_LUI    = 7;
    localparam int unsigned OP_AUIPC  = 8;
    localparam int unsigned OP_SYSTEM = 9;
    localparam int unsigned OP_FENCE  = 10;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_AND  = 6;
    localparam int unsigned ALU_SLL  = 7;
    localparam int unsigned ALU_SRL  = 8;
    localparam int unsigned ALU_SRA  = 9;
    localparam int unsigned ALU_EQ   = 10;
    localparam int unsigned ALU_NEQ  = 11;
    localparam int unsigned ALU_GE   = 12;
    localparam int unsigned ALU_GEU  = 13;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rd;
        logic [IMM_W-1:0]    imm;
        logic [F3_W-1:0]     funct3;
        logic [OPC_W-1:0]    opcode;
        logic [ALU_W-1:0]    alu_op;
        logic                rd_we;
        logic                illegal;
    } dec_t;

    // Register-register / register-immediate ALU selection by funct3.
    function automatic logic [ALU_W-1:0] arith_alu(input logic [F3_W-1:0] f3,
                                                   input logic alt_sub,
                                                   input logic alt_sra);
        logic [ALU_W-1:0] oh;
        oh = '0;
        case (f3)
            3'b000:  oh[alt_sub ? ALU_SUB : ALU_ADD] = 1'b1;
            3'b001:  oh[ALU_SLL]  = 1'b1;
            3'b010:  oh[ALU_SLT]  = 1'b1;
            3'b011:  oh[ALU_SLTU] = 1'b1;
            3'b100:  oh[ALU_XOR]  = 1'b1;
            3'b101:  oh[alt_sra ? ALU_SRA : ALU_SRL] = 1'b1;
            3'b110:  oh[ALU_OR]   = 1'b1;
            default: oh[ALU_AND]  = 1'b1;
        endcase
        return oh;
    endfunction

    logic [31:0]      inst_c;
    logic [F3_W-1:0]  f3_c;
    logic [6:0]       f7_c;
    logic [IMM_W-1:0] imm_i_c, imm_s_c, imm_b_c, imm_j_c, imm_u_c;
    logic [IMM_W-1:0] imm_c;
    logic [OPC_W-1:0] opc_c;
    logic [ALU_W-1:0] alu_c;
    logic             illegal_c;
    logic             use_rs1_c, use_rs2_c, use_rd_c;
    logic             rd_we_c;
    dec_t             dec_c;

    assign inst_c  = dec.i_inst;
    assign f3_c    = inst_c[14:12];
    assign f7_c    = inst_c[31:25];
    assign imm_i_c = {{20{inst_c[31]}}, inst_c[31:20]};
    assign imm_s_c = {{20{inst_c[31]}}, inst_c[31:25], inst_c[11:7]};
    assign imm_b_c = {{19{inst_c[31]}}, inst_c[31], inst_c[7], inst_c[30:25], inst_c[11:8], 1'b0};
    assign imm_j_c = {{11{inst_c[31]}}, inst_c[31], inst_c[19:12], inst_c[20], inst_c[30:21], 1'b0};
    assign imm_u_c = {inst_c[31:12], 12'b0};

    // Opcode class, immediate format, ALU op and legality of the incoming word.
    always_comb begin
        opc_c     = '0;
        alu_c     = '0;
        imm_c     = '0;
        illegal_c = 1'b0;
        use_rs1_c = 1'b0;
        use_rs2_c = 1'b0;
        use_rd_c  = 1'b0;
        case (inst_c[6:0])
            OPC_RTYPE: begin
                opc_c[OP_RTYPE] = 1'b1;
                use_rs1_c = 1'b1; use_rs2_c = 1'b1; use_rd_c = 1'b1;
                alu_c = arith_alu(f3_c, inst_c[30], inst_c[30]);
                if (!((f7_c == 7'b0000000) ||
                      ((f7_c == 7'b0100000) && ((f3_c == 3'b000) || (f3_c == 3'b101)))))
                    illegal_c = 1'b1;
            end
            OPC_ITYPE: begin
                opc_c[OP_ITYPE] = 1'b1;
                use_rs1_c = 1'b1; use_rd_c = 1'b1;
                imm_c = imm_i_c;
                alu_c = arith_alu(f3_c, 1'b0, inst_c[30]);
                if (((f3_c == 3'b001) && (f7_c != 7'b0000000)) ||
                    ((f3_c == 3'b101) && (f7_c != 7'b0000000) && (f7_c != 7'b0100000)))
                    illegal_c = 1'b1;
            end
            OPC_LOAD: begin
                opc_c[OP_LOAD] = 1'b1;
                use_rs1_c = 1'b1; use_rd_c = 1'b1;
                imm_c = imm_i_c;
                alu_c[ALU_ADD] = 1'b1;
                if ((f3_c == 3'b011) || (f3_c == 3'b110) || (f3_c == 3'b111))
                    illegal_c = 1'b1;
            end
            OPC_STORE: begin
                opc_c[OP_STORE] = 1'b1;
                use_rs1_c = 1'b1; use_rs2_c = 1'b1;
                imm_c = imm_s_c;
                alu_c[ALU_ADD] = 1'b1;
                if (f3_c >= 3'b011)
                    illegal_c = 1'b1;
            end
            OPC_BRANCH: begin
                opc_c[OP_BRANCH] = 1'b1;
                use_rs1_c = 1'b1; use_rs2_c = 1'b1;
                imm_c = imm_b_c;
                case (f3_c)
                    3'b000:  alu_c[ALU_EQ]   = 1'b1;
                    3'b001:  alu_c[ALU_NEQ]  = 1'b1;
                    3'b100:  alu_c[ALU_SLT]  = 1'b1;
                    3'b101:  alu_c[ALU_GE]   = 1'b1;
                    3'b110:  alu_c[ALU_SLTU] = 1'b1;
                    3'b111:  alu_c[ALU_GEU]  = 1'b1;
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_JAL: begin
                opc_c[OP_JAL] = 1'b1;
                use_rd_c = 1'b1;
                imm_c = imm_j_c;
                alu_c[ALU_ADD] = 1'b1;
            end
            OPC_JALR: begin
                opc_c[OP_JALR] = 1'b1;
                use_rs1_c = 1'b1; use_rd_c = 1'b1;
                imm_c = imm_i_c;
                alu_c[ALU_ADD] = 1'b1;
                if (f3_c != 3'b000)
                    illegal_c = 1'b1;
            end
            OPC_LUI: begin
                opc_c[OP_LUI] = 1'b1;
                use_rd_c = 1'b1;
                imm_c = imm_u_c;
                alu_c[ALU_ADD] = 1'b1;
            end
            OPC_AUIPC: begin
                opc_c[OP_AUIPC] = 1'b1;
                use_rd_c = 1'b1;
                imm_c = imm_u_c;
                alu_c[ALU_ADD] = 1'b1;
            end
            OPC_SYSTEM: begin
                opc_c[OP_SYSTEM] = 1'b1;
                alu_c[ALU_ADD] = 1'b1;
            end
            OPC_FENCE: begin
                opc_c[OP_FENCE] = 1'b1;
                alu_c[ALU_ADD] = 1'b1;
            end
            default: illegal_c = 1'b1;
        endcase

        // RV32E only has x0..x15; bit 4 of any register field in use is illegal.
        if (RV32E && ((use_rs1_c && inst_c[19]) || (use_rs2_c && inst_c[24]) ||
                      (use_rd_c && inst_c[11])))
            illegal_c = 1'b1;

        if (illegal_c) begin
            opc_c = '0;
            alu_c = '0;
        end
    end

    assign rd_we_c = !illegal_c && use_rd_c && (inst_c[11:7] != 5'd0);

    always_comb begin
        dec_c         = '0;
        dec_c.pc      = dec.i_pc;
        dec_c.rs1     = inst_c[19:15];
        dec_c.rs2     = inst_c[24:20];
        dec_c.rd      = inst_c[11:7];
        dec_c.imm     = imm_c;
        dec_c.funct3  = f3_c;
        dec_c.opcode  = opc_c;
        dec_c.alu_op  = alu_c;
        dec_c.rd_we   = rd_we_c;
        dec_c.illegal = illegal_c;
    end

    // Output register: flush beats load, load beats drain, otherwise hold.
    logic valid_q, valid_d;
    dec_t pay_q, pay_d;
    logic ready_c, load_c;

    assign ready_c = !valid_q || dec.i_ready;
    assign load_c  = dec.i_valid && ready_c && !dec.i_flush;

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (dec.i_flush) begin
            valid_d = 1'b0;
        end else if (load_c) begin
            valid_d = 1'b1;
            pay_d   = dec_c;
        end else if (dec.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign dec.o_ready    = ready_c;
    assign dec.o_valid    = valid_q;
    assign dec.o_pc       = pay_q.pc;
    assign dec.o_rs1_addr = pay_q.rs1;
    assign dec.o_rs2_addr = pay_q.rs2;
    assign dec.o_rd_addr  = pay_q.rd;
    assign dec.o_imm      = pay_q.imm;
    assign dec.o_funct3   = pay_q.funct3;
    assign dec.o_opcode   = pay_q.opcode;
    assign dec.o_alu_op   = pay_q.alu_op;
    assign dec.o_rd_we    = pay_q.rd_we;
    assign dec.o_illegal  = pay_q.illegal;
endmodule
